mips_mem_arbiter: RTL and testbench

- Sequences a single shared word-addressed memory between the pipeline's instruction fetch (IF) port and data (MEM-stage) port.
- Sits between the pipelined_mips_forwarding core and a unified instruction/data memory.
- Issues one memory access at a time and waits a fixed memory latency.
- Returns read data and a one-cycle ready pulse to the winning requester; drives stall indications back to the pipeline.

---
 rtl/mips_mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mem_arbiter
//  Description : Sequences one shared word-addressed memory between the
//                pipeline instruction-fetch port and the data port. One
//                access in flight at a time, fixed memory latency, one-cycle
//                ready pulse to the winner, combinational stall back to the
//                pipeline. DM wins contention unless IF has lost STARVE_LIM
//                arbitrations in a row.
//                Optional macro ARB_PERF_CNT_EN adds perf_if_stall and
//                perf_dm_acc saturating performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_mem_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 3,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_ready,
    output logic              stall_if,
    output logic              stall_dm,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_stall,
    output logic [31:0]       perf_dm_acc
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [2:0] c_mem_lat    = 3'(MEM_LAT);
    localparam logic [3:0] c_starve_lim = 4'(STARVE_LIM);
    localparam logic [3:0] c_starve_max = 4'hF;

    state_t              r_state;
    state_t              w_next_state;
    logic [2:0]          r_lat_cnt;
    logic [3:0]          r_starve;
    logic                r_owner_dm;
    logic                r_mem_en;
    logic                r_mem_wr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [31:0]         r_if_rdata;
    logic [31:0]         r_dm_rdata;
    logic                w_grant_if;
    logic                w_grant_dm;
    logic                w_capture;
    logic                w_busy;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Arbitration, latency wait and completion sequencing
    always_comb begin
        w_next_state = r_state;
        w_grant_if   = 1'b0;
        w_grant_dm   = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // DM normally wins; a starved IF takes the slot instead
                if (dm_req && (!if_req || (r_starve < c_starve_lim))) begin
                    w_grant_dm   = 1'b1;
                    w_next_state = ST_BUSY_DM;
                end else if (if_req) begin
                    w_grant_if   = 1'b1;
                    w_next_state = ST_BUSY_IF;
                end
            end
            ST_BUSY_IF, ST_BUSY_DM: begin
                if (r_lat_cnt == 3'd0) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_busy = (r_state == ST_BUSY_IF) || (r_state == ST_BUSY_DM);

    // Memory request registers and latency counter, loaded on a grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat_cnt   <= 3'd0;
            r_owner_dm  <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
        end else begin
            // strobe lasts exactly the cycle after the grant
            r_mem_en <= w_grant_if | w_grant_dm;
            r_mem_wr <= w_grant_dm & dm_wr;
            if (w_grant_dm) begin
                r_owner_dm  <= 1'b1;
                r_mem_addr  <= dm_addr;
                r_mem_wdata <= dm_wdata;
                r_lat_cnt   <= c_mem_lat;
            end else if (w_grant_if) begin
                r_owner_dm  <= 1'b0;
                r_mem_addr  <= if_addr;
                r_lat_cnt   <= c_mem_lat;
            end else if (w_busy && (r_lat_cnt != 3'd0)) begin
                r_lat_cnt <= r_lat_cnt - 3'd1;
            end
        end
    end

    // Starvation counter: counts IF losses under contention
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= 4'd0;
        end else if (w_grant_if) begin
            r_starve <= 4'd0;
        end else if (w_grant_dm && if_req && (r_starve != c_starve_max)) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    // Read data capture; values hold until the owner's next capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_rdata <= 32'd0;
            r_dm_rdata <= 32'd0;
        end else if (w_capture) begin
            if (r_owner_dm) begin
                r_dm_rdata <= mem_rdata;
            end else begin
                r_if_rdata <= mem_rdata;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_if_stall;
    logic [31:0] r_perf_dm_acc;

    // Saturating stall-cycle and DM-grant counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_if_stall <= 32'd0;
            r_perf_dm_acc   <= 32'd0;
        end else begin
            if (stall_if && (r_perf_if_stall != 32'hFFFF_FFFF)) begin
                r_perf_if_stall <= r_perf_if_stall + 32'd1;
            end
            if (w_grant_dm && (r_perf_dm_acc != 32'hFFFF_FFFF)) begin
                r_perf_dm_acc <= r_perf_dm_acc + 32'd1;
            end
        end
    end

    assign perf_if_stall = r_perf_if_stall;
    assign perf_dm_acc   = r_perf_dm_acc;
`endif

    assign if_ready  = (r_state == ST_DONE) && !r_owner_dm;
    assign dm_ready  = (r_state == ST_DONE) &&  r_owner_dm;
    assign stall_if  = if_req & ~if_ready;
    assign stall_dm  = dm_req & ~dm_ready;
    assign mem_en    = r_mem_en;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mips_mem_arbiter
//  Description : Self-checking bench for mips_mem_arbiter. A transaction-level
//                schedule model predicts grants, strobes and ready pulses;
//                directed scenarios pin literal timings, random traffic
//                exercises the rest. Honors ARB_PERF_CNT_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mem_arbiter;

    localparam int MEM_LAT    = 1;
    localparam int STARVE_LIM = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT (MEM_LAT = 1)
    logic        rst, if_req, dm_req, dm_wr;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, dm_ready, stall_if, stall_dm, mem_en, mem_wr;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall, perf_dm_acc;
`endif

    mips_mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_LIM(STARVE_LIM), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .stall_if(stall_if), .stall_dm(stall_dm),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
        , .perf_if_stall(perf_if_stall), .perf_dm_acc(perf_dm_acc)
`endif
    );

    // second DUT (MEM_LAT = 4) for the long-latency timing check
    logic        b_rst, b_if_req, b_dm_req, b_dm_wr;
    logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata, b_mem_rdata;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
    logic        b_if_ready, b_dm_ready, b_stall_if, b_stall_dm, b_mem_en, b_mem_wr;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] b_perf_if_stall, b_perf_dm_acc;
`endif

    mips_mem_arbiter #(.MEM_LAT(4), .STARVE_LIM(STARVE_LIM), .ADDR_W(32)) dut4 (
        .clk(clk), .rst(b_rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
        .dm_req(b_dm_req), .dm_wr(b_dm_wr), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_rdata(b_dm_rdata), .dm_ready(b_dm_ready),
        .stall_if(b_stall_if), .stall_dm(b_stall_dm),
        .mem_en(b_mem_en), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
`ifdef ARB_PERF_CNT_EN
        , .perf_if_stall(b_perf_if_stall), .perf_dm_acc(b_perf_dm_acc)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // staged inputs, applied at the next falling edge
    logic        s_rst, s_if_req, s_dm_req, s_dm_wr;
    logic [31:0] s_if_addr, s_dm_addr, s_dm_wdata;

    // transaction-level model
    bit          m_active;
    int          m_iss;
    int          m_next_arb;
    int          m_starve;
    bit          m_owner_dm;
    bit          m_wr;
    logic [31:0] m_addr, m_wdata, m_rd_exp;
    logic [31:0] mm   [logic [31:0]];
    logic [31:0] rmem [logic [31:0]];
    logic [31:0] m_perf_stall, m_perf_dm;
    bit          e_if_ready, e_dm_ready, g_if, g_dm;
    int          due;
    logic [31:0] due_val;
    string       model_order;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] rand_addr();
        return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: actual %h required %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: actual %b required %b", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare against the model, advance it
    task automatic step();
        bit e_mem_en, e_rdy;
        @(negedge clk);
        rst      = s_rst;
        if_req   = s_if_req;
        if_addr  = s_if_addr;
        dm_req   = s_dm_req;
        dm_wr    = s_dm_wr;
        dm_addr  = s_dm_addr;
        dm_wdata = s_dm_wdata;
        mem_rdata = (cyc == due) ? due_val : $urandom();
        #1;
        e_mem_en   = m_active && (cyc == m_iss + 1);
        e_rdy      = m_active && (cyc == m_iss + MEM_LAT + 2);
        e_if_ready = e_rdy && !m_owner_dm;
        e_dm_ready = e_rdy &&  m_owner_dm;
        chk1("mem_en", mem_en, e_mem_en);
        chk1("mem_wr", mem_wr, e_mem_en && m_wr);
        if (e_mem_en) begin
            chk32("mem_addr", mem_addr, m_addr);
            if (m_wr) chk32("mem_wdata", mem_wdata, m_wdata);
        end
        chk1("if_ready", if_ready, e_if_ready);
        chk1("dm_ready", dm_ready, e_dm_ready);
        chk1("stall_if", stall_if, if_req && !e_if_ready);
        chk1("stall_dm", stall_dm, dm_req && !e_dm_ready);
        if (e_if_ready) chk32("if_rdata", if_rdata, m_rd_exp);
        if (e_dm_ready && !m_wr) chk32("dm_rdata", dm_rdata, m_rd_exp);
`ifdef ARB_PERF_CNT_EN
        chk32("perf_if_stall", perf_if_stall, m_perf_stall);
        chk32("perf_dm_acc", perf_dm_acc, m_perf_dm);
`endif
        // memory responder follows what the DUT actually issued
        if (mem_en === 1'b1) begin
            if (mem_wr === 1'b1) begin
                rmem[mem_addr] = mem_wdata;
            end else begin
                due     = cyc + MEM_LAT;
                due_val = rmem.exists(mem_addr) ? rmem[mem_addr] : mem_init(mem_addr);
            end
        end
        // model advance
        g_if = 1'b0;
        g_dm = 1'b0;
        if (e_rdy) m_active = 1'b0;
        if (rst) begin
            m_active     = 1'b0;
            m_next_arb   = cyc + 1;
            m_starve     = 0;
            due          = -1;
            m_perf_stall = 32'd0;
            m_perf_dm    = 32'd0;
        end else begin
            if (if_req && !e_if_ready && m_perf_stall != 32'hFFFF_FFFF)
                m_perf_stall = m_perf_stall + 32'd1;
            if (cyc >= m_next_arb) begin
                if (dm_req && (!if_req || m_starve < STARVE_LIM)) begin
                    g_dm = 1'b1;
                    if (if_req) m_starve = (m_starve >= 15) ? 15 : m_starve + 1;
                end else if (if_req) begin
                    g_if = 1'b1;
                    m_starve = 0;
                end
                if (g_if || g_dm) begin
                    m_active   = 1'b1;
                    m_iss      = cyc;
                    m_next_arb = cyc + MEM_LAT + 3;
                    m_owner_dm = g_dm;
                    m_addr     = g_dm ? dm_addr : if_addr;
                    m_wr       = g_dm && dm_wr;
                    m_wdata    = dm_wdata;
                    m_rd_exp   = mm.exists(m_addr) ? mm[m_addr] : mem_init(m_addr);
                    if (m_wr) mm[m_addr] = m_wdata;
                    if (g_dm && m_perf_dm != 32'hFFFF_FFFF) m_perf_dm = m_perf_dm + 32'd1;
                    model_order = {model_order, g_dm ? "D" : "I"};
                end else begin
                    m_next_arb = cyc + 1;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        int          en_rel, rdy_rel, stall_n, en_n, rdy_n;
        logic [31:0] got;
        bit          seen_wr, got_rdy, both;
        string       dut_order;
        bit          if_busy, if_gnt, dm_busy, dm_gnt;

        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        b_rst = 1'b1; b_if_req = 1'b0; b_dm_req = 1'b0; b_dm_wr = 1'b0;
        b_if_addr = '0; b_dm_addr = '0; b_dm_wdata = '0; b_mem_rdata = '0;
        s_rst = 1'b1; s_if_req = 1'b0; s_dm_req = 1'b0; s_dm_wr = 1'b0;
        s_if_addr = '0; s_dm_addr = '0; s_dm_wdata = '0;
        m_active = 1'b0; m_iss = 0; m_next_arb = 0; m_starve = 0; m_owner_dm = 1'b0;
        m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_rd_exp = '0;
        m_perf_stall = '0; m_perf_dm = '0; due = -1; due_val = '0;
        model_order = "";
        mm[32'h4]   = 32'h2008_0005;
        rmem[32'h4] = 32'h2008_0005;
        repeat (3) @(negedge clk);

        // reset state
        step();
        s_rst = 1'b0;
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_if_ready", if_ready, 1'b0);
        chk1("rst_dm_ready", dm_ready, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'd0);
        chk32("rst_if_rdata", if_rdata, 32'd0);
        chk32("rst_dm_rdata", dm_rdata, 32'd0);

        // single fetch
        s_if_req = 1'b1; s_if_addr = 32'h0000_0004;
        en_rel = -1; rdy_rel = -1; stall_n = 0; got = '0;
        for (int r = 0; r < 8; r++) begin
            step();
            if (mem_en) en_rel = r;
            if (stall_if) stall_n++;
            if (if_ready) begin rdy_rel = r; got = if_rdata; s_if_req = 1'b0; end
        end
        chk32("if_mem_en_cycle", 32'(en_rel), 32'd1);
        chk32("if_ready_cycle", 32'(rdy_rel), 32'd3);
        chk32("if_fetch_data", got, 32'h2008_0005);
        chk32("if_stall_cycles", 32'(stall_n), 32'd3);
`ifdef ARB_PERF_CNT_EN
        chk32("perf_stall_single", perf_if_stall, 32'd3);
        chk32("perf_dm_zero", perf_dm_acc, 32'd0);
`endif

        // store then load of the same word
        s_dm_req = 1'b1; s_dm_wr = 1'b1; s_dm_addr = 32'h10; s_dm_wdata = 32'hDEAD_BEEF;
        seen_wr = 1'b0; got_rdy = 1'b0;
        for (int r = 0; r < 12 && !got_rdy; r++) begin
            step();
            if (mem_en && mem_wr && mem_addr == 32'h10) seen_wr = 1'b1;
            if (dm_ready) got_rdy = 1'b1;
        end
        chk1("store_mem_wr", seen_wr, 1'b1);
        chk1("store_ready", got_rdy, 1'b1);
        s_dm_wr = 1'b0; s_dm_wdata = 32'd0;
        got_rdy = 1'b0; got = '0;
        for (int r = 0; r < 12 && !got_rdy; r++) begin
            step();
            if (dm_ready) begin got_rdy = 1'b1; got = dm_rdata; end
        end
        s_dm_req = 1'b0;
        chk1("load_ready", got_rdy, 1'b1);
        chk32("load_data", got, 32'hDEAD_BEEF);
`ifdef ARB_PERF_CNT_EN
        chk32("perf_dm_two", perf_dm_acc, 32'd2);
`endif
        step();

        // sustained contention
        s_if_req = 1'b1; s_if_addr = 32'h100;
        s_dm_req = 1'b1; s_dm_wr = 1'b0; s_dm_addr = 32'h200;
        dut_order = ""; model_order = ""; both = 1'b0;
        for (int r = 0; r < 80 && dut_order.len() < 8; r++) begin
            step();
            if (if_ready && dm_ready) both = 1'b1;
            if (mem_en) dut_order = {dut_order, (mem_addr == 32'h200) ? "D" : "I"};
        end
        checks++;
        if (dut_order != "DDDIDDDI") begin
            errors++;
            $display("FAIL grant_order: actual %s required DDDIDDDI", dut_order);
        end
        checks++;
        if (model_order.substr(0, 7) != "DDDIDDDI") begin
            errors++;
            $display("FAIL model_grant_order: actual %s required DDDIDDDI", model_order);
        end
        chk1("both_ready", both, 1'b0);
        s_if_req = 1'b0; s_dm_req = 1'b0;
        repeat (6) step();

        // reset in the middle of a data load
        s_dm_req = 1'b1; s_dm_wr = 1'b0; s_dm_addr = 32'h10;
        got_rdy = 1'b0;
        for (int r = 0; r < 10 && !got_rdy; r++) begin
            step();
            if (mem_en) got_rdy = 1'b1;
        end
        chk1("abort_load_issued", got_rdy, 1'b1);
        s_rst = 1'b1; s_dm_req = 1'b0;
        step();
        s_rst = 1'b0;
        step();
        chk1("abort_mem_en", mem_en, 1'b0);
        chk32("abort_mem_addr", mem_addr, 32'd0);
        chk32("abort_if_rdata", if_rdata, 32'd0);
        chk32("abort_dm_rdata", dm_rdata, 32'd0);
        rdy_n = 0;
        for (int r = 0; r < 5; r++) begin
            if (dm_ready) rdy_n++;
            step();
        end
        chk32("abort_no_ready", 32'(rdy_n), 32'd0);
        s_if_req = 1'b1; s_if_addr = 32'h4;
        got_rdy = 1'b0; got = '0;
        for (int r = 0; r < 12 && !got_rdy; r++) begin
            step();
            if (if_ready) begin got_rdy = 1'b1; got = if_rdata; end
        end
        s_if_req = 1'b0;
        chk1("post_rst_fetch", got_rdy, 1'b1);
        chk32("post_rst_data", got, 32'h2008_0005);
        step();

        // randomized traffic
        if_busy = 1'b0; if_gnt = 1'b0; dm_busy = 1'b0; dm_gnt = 1'b0;
        for (int r = 0; r < 3000; r++) begin
            step();
            if (e_if_ready) if_busy = 1'b0;
            if (e_dm_ready) dm_busy = 1'b0;
            if (g_if) if_gnt = 1'b1;
            if (g_dm) dm_gnt = 1'b1;
            if (rst) begin if_busy = 1'b0; dm_busy = 1'b0; end
            s_rst = ($urandom_range(0, 99) == 0);
            if (!if_busy) begin
                if ($urandom_range(0, 1) == 1) begin
                    if_busy = 1'b1; if_gnt = 1'b0; s_if_req = 1'b1; s_if_addr = rand_addr();
                end else begin
                    s_if_req = 1'b0; s_if_addr = $urandom();
                end
            end else if (if_gnt && $urandom_range(0, 3) == 0) begin
                s_if_req = 1'b0; s_if_addr = $urandom();
            end
            if (!dm_busy) begin
                if ($urandom_range(0, 1) == 1) begin
                    dm_busy = 1'b1; dm_gnt = 1'b0; s_dm_req = 1'b1; s_dm_addr = rand_addr();
                    s_dm_wr = 1'($urandom_range(0, 1)); s_dm_wdata = $urandom();
                end else begin
                    s_dm_req = 1'b0; s_dm_addr = $urandom(); s_dm_wr = 1'($urandom_range(0, 1));
                end
            end else if (dm_gnt && $urandom_range(0, 3) == 0) begin
                s_dm_req = 1'b0; s_dm_addr = $urandom(); s_dm_wdata = $urandom();
            end
        end

        // long-latency instance: one load
        @(negedge clk);
        b_rst = 1'b0;
        en_n = 0; en_rel = -1; rdy_rel = -1; rdy_n = 0; got = '0; got_rdy = 1'b0;
        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            if (r == 0) begin b_dm_req = 1'b1; b_dm_wr = 1'b0; b_dm_addr = 32'h40; end
            if (got_rdy) b_dm_req = 1'b0;
            b_mem_rdata = 32'hCAFE_0000 + 32'(r);
            #1;
            if (b_mem_en) begin
                en_n++; en_rel = r;
                chk32("lat4_mem_addr", b_mem_addr, 32'h40);
            end
            if (b_dm_ready) begin rdy_n++; rdy_rel = r; got = b_dm_rdata; got_rdy = 1'b1; end
        end
        chk32("lat4_mem_en_count", 32'(en_n), 32'd1);
        chk32("lat4_mem_en_cycle", 32'(en_rel), 32'd1);
        chk32("lat4_ready_cycle", 32'(rdy_rel), 32'd6);
        chk32("lat4_ready_count", 32'(rdy_n), 32'd1);
        chk32("lat4_data", got, 32'hCAFE_0005);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
